// File: rtl/lowx_arbiter.sv
// Shares one lower-level memory port between icache and dcache refill/writeback
// requests. Holds one outstanding transaction, grants round-robin, routes responses back.
module lowx_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  output logic              ic_res_valid_o,
  output logic [BLK_W-1:0]  ic_res_data_o,
  input  logic              dc_req_valid_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic              dc_req_rw_i,
  input  logic [BLK_W-1:0]  dc_req_data_i,
  output logic              dc_req_ready_o,
  output logic              dc_res_valid_o,
  output logic [BLK_W-1:0]  dc_res_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_rw_o,
  output logic [BLK_W-1:0]  mem_req_data_o,
  input  logic              mem_res_valid_i,
  input  logic [BLK_W-1:0]  mem_res_data_i
);

  // state | meaning
  // IDLE  | no transaction; grant a requester combinationally
  // REQ   | presenting latched request downstream, waiting for mem_req_ready_i
  // RESP  | request accepted, waiting for mem_res_valid_i
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;
  logic   owner, prio;
  logic   grant_ic, grant_dc, complete;

  always_comb begin
    state_nxt = state;
    grant_ic  = 1'b0;
    grant_dc  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no ready pulse escapes while rst_i is held.
        if (!rst_i) begin
          if (ic_req_valid_i && (!dc_req_valid_i || !prio)) grant_ic = 1'b1;
          else if (dc_req_valid_i)                          grant_dc = 1'b1;
          if (grant_ic || grant_dc) state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          if (mem_res_valid_i) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (mem_res_valid_i) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      owner          <= 1'b0;
      prio           <= 1'b1;
      mem_req_addr_o <= '0;
      mem_req_rw_o   <= 1'b0;
      mem_req_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ic || grant_dc) begin
        owner          <= grant_dc;
        prio           <= grant_ic;
        mem_req_addr_o <= grant_dc ? dc_req_addr_i : ic_req_addr_i;
        mem_req_rw_o   <= grant_dc & dc_req_rw_i;
        mem_req_data_o <= grant_dc ? dc_req_data_i : '0;
      end
    end
  end

  // Response pulses and data are registered; data holds between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ic_res_valid_o <= 1'b0;
      dc_res_valid_o <= 1'b0;
      ic_res_data_o  <= '0;
      dc_res_data_o  <= '0;
    end else begin
      ic_res_valid_o <= complete & ~owner;
      dc_res_valid_o <= complete & owner;
      if (complete && !owner) ic_res_data_o <= mem_res_data_i;
      if (complete && owner)  dc_res_data_o <= mem_res_data_i;
    end
  end

  assign ic_req_ready_o  = grant_ic;
  assign dc_req_ready_o  = grant_dc;
  assign mem_req_valid_o = (state == REQ);

endmodule
